// File: rtl/neural_net_pkg.sv
// Shared types and constants for the neural-net datapath blocks.
package neural_net_pkg;

  // Default fixed-point format: Q7.8 in a 16-bit signed word
  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_FRAC_BITS  = 8;

  // Saturation bounds at the default data width
  localparam logic signed [DEFAULT_DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DEFAULT_DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DEFAULT_DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DEFAULT_DATA_WIDTH-1){1'b0}}};

  // Frame assembly states
  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FLUSH   = 2'd1,
    FULL    = 2'd2
  } state_t;

  // Signed sample at the default width
  typedef logic signed [DEFAULT_DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/saturating_fixed_multiplier.sv
// Combinational signed fixed-point multiply: full-width product, arithmetic
// shift down by FRAC_BITS (floor rounding), then clip to the signed range.
module saturating_fixed_multiplier #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [DATA_WIDTH-1:0] product,
  output logic                         sat
);

  localparam int WIDE = 2 * DATA_WIDTH;

  // Output range limits, expressed both at full width (for comparison) and
  // at data width (for the clipped result)
  localparam logic signed [WIDE-1:0] MAX_WIDE = {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [WIDE-1:0] MIN_WIDE = {{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] MAX_DATA = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] MIN_DATA = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [WIDE-1:0] full_product;
  logic signed [WIDE-1:0] shifted;

  // Multiply, rescale and clip
  always_comb begin
    full_product = a * b;
    shifted      = full_product >>> FRAC_BITS;
    product      = shifted[DATA_WIDTH-1:0];
    sat          = 1'b0;
    if (shifted > MAX_WIDE) begin
      product = MAX_DATA;
      sat     = 1'b1;
    end else if (shifted < MIN_WIDE) begin
      product = MIN_DATA;
      sat     = 1'b1;
    end
  end

endmodule

// File: rtl/weighted_input_buffer.sv
// Collects one weighted activation per accepted sample into slot order and
// presents the finished frame as a packed vector until it is acknowledged.
module weighted_input_buffer
  import neural_net_pkg::*;
#(
  parameter int DATA_WIDTH       = DEFAULT_DATA_WIDTH,
  parameter int FRAC_BITS        = DEFAULT_FRAC_BITS,
  parameter int NUMBER_OF_INPUTS = 64
) (
  input  logic                                     clk_in,
  input  logic                                     rst_in,
  input  logic signed [DATA_WIDTH-1:0]             input_data_in,
  input  logic                                     input_valid_in,
  output logic                                     input_ready_out,
  input  logic                                     weight_wr_en_in,
  input  logic [$clog2(NUMBER_OF_INPUTS)-1:0]      weight_addr_in,
  input  logic signed [DATA_WIDTH-1:0]             weight_data_in,
  output logic [NUMBER_OF_INPUTS*DATA_WIDTH-1:0]   products_out,
  output logic                                     products_valid_out,
  input  logic                                     products_ack_in,
  output logic                                     saturated_out
);

  localparam int IDX_W = $clog2(NUMBER_OF_INPUTS);
  localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(NUMBER_OF_INPUTS - 1);

  state_t                      state_reg;
  logic [IDX_W-1:0]            index_reg;
  logic signed [DATA_WIDTH-1:0] weight_reg [NUMBER_OF_INPUTS];
  logic signed [DATA_WIDTH-1:0] product_array_reg [NUMBER_OF_INPUTS];

  logic                        pipe_valid_reg;
  logic signed [DATA_WIDTH-1:0] pipe_product_reg;
  logic                        pipe_sat_reg;
  logic [IDX_W-1:0]            pipe_slot_reg;
  logic                        sat_accum_reg;

  logic                        accept;
  logic signed [DATA_WIDTH-1:0] current_weight;
  logic signed [DATA_WIDTH-1:0] mult_product;
  logic                        mult_sat;

  assign input_ready_out    = (state_reg == COLLECT);
  assign accept             = input_valid_in && input_ready_out;
  // Read happens before any same-edge write lands, so a colliding write only
  // affects the next frame
  assign current_weight     = weight_reg[index_reg];
  assign products_valid_out = (state_reg == FULL);
  assign saturated_out      = (state_reg == FULL) && sat_accum_reg;

  saturating_fixed_multiplier #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_mult (
    .a       (input_data_in),
    .b       (current_weight),
    .product (mult_product),
    .sat     (mult_sat)
  );

  // Weight register file, writable in every state
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUMBER_OF_INPUTS; i++) weight_reg[i] <= '0;
    end else if (weight_wr_en_in) begin
      weight_reg[weight_addr_in] <= weight_data_in;
    end
  end

  // Frame state and slot index
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg <= COLLECT;
      index_reg <= '0;
    end else begin
      case (state_reg)
        COLLECT: begin
          if (accept) begin
            index_reg <= index_reg + 1'b1;  // wraps to 0 after the last slot
            if (index_reg == LAST_INDEX) state_reg <= FLUSH;
          end
        end
        FLUSH:   state_reg <= FULL;
        FULL:    if (products_ack_in) state_reg <= COLLECT;
        default: state_reg <= COLLECT;
      endcase
    end
  end

  // Single pipeline stage between the multiplier and the slot store
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pipe_valid_reg   <= 1'b0;
      pipe_product_reg <= '0;
      pipe_sat_reg     <= 1'b0;
      pipe_slot_reg    <= '0;
    end else begin
      pipe_valid_reg <= accept;
      if (accept) begin
        pipe_product_reg <= mult_product;
        pipe_sat_reg     <= mult_sat;
        pipe_slot_reg    <= index_reg;
      end
    end
  end

  // Slot store; old contents persist until overwritten by the next frame
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUMBER_OF_INPUTS; i++) product_array_reg[i] <= '0;
    end else if (pipe_valid_reg) begin
      product_array_reg[pipe_slot_reg] <= pipe_product_reg;
    end
  end

  // Sticky clip flag for the frame, cleared when the frame is acknowledged
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sat_accum_reg <= 1'b0;
    end else if ((state_reg == FULL) && products_ack_in) begin
      sat_accum_reg <= 1'b0;
    end else if (pipe_valid_reg && pipe_sat_reg) begin
      sat_accum_reg <= 1'b1;
    end
  end

  // Pack slots with slot 0 in the least-significant element
  for (genvar gi = 0; gi < NUMBER_OF_INPUTS; gi++) begin : g_pack
    assign products_out[gi*DATA_WIDTH +: DATA_WIDTH] = product_array_reg[gi];
  end

endmodule
